// File: rtl/core_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : core_axi_bridge_if
// Description : Core-side SRAM-like request ports and AXI3 master channels
//               used by core_axi_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_axi_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    // instruction fetch port
    logic                  inst_req;
    logic [31:0]           inst_addr;
    logic [3:0]            inst_len;
    logic                  inst_addr_ok;
    logic [DATA_W-1:0]     inst_rdata;
    logic                  inst_rvalid;
    logic                  inst_rlast;

    // data port
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [31:0]           data_addr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_data_ok;

    // AXI3 read address / read data
    logic [ID_W-1:0]       m_axi_arid;
    logic [31:0]           m_axi_araddr;
    logic [3:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic [1:0]            m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_W-1:0]       m_axi_rid;
    logic [DATA_W-1:0]     m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    // AXI3 write address / write data / write response
    logic [ID_W-1:0]       m_axi_awid;
    logic [31:0]           m_axi_awaddr;
    logic [3:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic [1:0]            m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [ID_W-1:0]       m_axi_wid;
    logic [DATA_W-1:0]     m_axi_wdata;
    logic [DATA_W/8-1:0]   m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [ID_W-1:0]       m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    // bridge view: serves the core ports, masters the AXI bus
    modport master (
        input  inst_req, inst_addr, inst_len,
        output inst_addr_ok, inst_rdata, inst_rvalid, inst_rlast,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    // environment view: drives the core requests, acts as the AXI slave
    modport slave (
        output inst_req, inst_addr, inst_len,
        input  inst_addr_ok, inst_rdata, inst_rvalid, inst_rlast,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface
`default_nettype wire

// File: rtl/core_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : core_axi_bridge
// Description : Merges the core's instruction-fetch and data request ports
//               onto one AXI3 master with independent read and write FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
module core_axi_bridge #(
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int MAX_LEN = 16
) (
    input  wire logic           clock,
    input  wire logic           resetn,
    core_axi_bridge_if.master   bus
);
    localparam int                c_strb_w    = DATA_W / 8;
    localparam int                c_off       = (DATA_W == 64) ? 3 : 2;
    localparam logic [2:0]        c_inst_size = 3'(c_off);
    localparam logic [3:0]        c_max_len   = 4'(MAX_LEN - 1);
    localparam logic [ID_W-1:0]   c_id_inst   = '0;
    localparam logic [ID_W-1:0]   c_id_data   = ID_W'(1);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    rd_state_t              r_rd_state, w_rd_next;
    wr_state_t              r_wr_state, w_wr_next;

    logic [31:0]            r_ar_addr;
    logic [3:0]             r_ar_len;
    logic [2:0]             r_ar_size;
    logic [ID_W-1:0]        r_ar_id;
    logic                   r_rd_is_data;

    logic [31:0]            r_aw_addr;
    logic [2:0]             r_aw_size;
    logic [DATA_W-1:0]      r_w_data;
    logic [c_strb_w-1:0]    r_w_strb;
    logic                   r_aw_done;
    logic                   r_w_done;

    logic                   w_hazard;
    logic                   w_dread_req;
    logic                   w_acc_dread;
    logic                   w_acc_inst;
    logic                   w_acc_write;
    logic [3:0]             w_inst_len;
    logic                   w_awvalid;
    logic                   w_wvalid;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_data_beat;
    logic                   w_inst_beat;
    logic                   w_bready;
    logic                   w_unused;

    // A pending write blocks reads of the same bus word until its response is back
    assign w_hazard    = (r_wr_state != W_IDLE) &&
                         (bus.data_addr[31:c_off] == r_aw_addr[31:c_off]);
    assign w_dread_req = resetn && bus.data_req && !bus.data_wr && !w_hazard;
    assign w_inst_len  = (bus.inst_len > c_max_len) ? c_max_len : bus.inst_len;

    assign w_awvalid   = (r_wr_state == W_SEND) && !r_aw_done;
    assign w_wvalid    = (r_wr_state == W_SEND) && !r_w_done;
    assign w_aw_hs     = w_awvalid && bus.m_axi_awready;
    assign w_w_hs      = w_wvalid && bus.m_axi_wready;

    assign w_data_beat = (r_rd_state == R_DATA) &&  r_rd_is_data && bus.m_axi_rvalid;
    assign w_inst_beat = (r_rd_state == R_DATA) && !r_rd_is_data && bus.m_axi_rvalid;
    // Hold off B while a data-read beat returns so data_data_ok never merges two completions
    assign w_bready    = (r_wr_state == W_RESP) && !w_data_beat;

    // ------------------------------------------------------------------ read FSM
    always_comb begin
        w_rd_next   = r_rd_state;
        w_acc_dread = 1'b0;
        w_acc_inst  = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (w_dread_req) begin
                    w_acc_dread = 1'b1;
                    w_rd_next   = R_AR;
                end else if (resetn && bus.inst_req) begin
                    w_acc_inst  = 1'b1;
                    w_rd_next   = R_AR;
                end
            end
            R_AR: begin
                if (bus.m_axi_arready) begin
                    w_rd_next = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.m_axi_rvalid && bus.m_axi_rlast) begin
                    w_rd_next = R_IDLE;
                end
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rd_state   <= R_IDLE;
            r_ar_addr    <= '0;
            r_ar_len     <= '0;
            r_ar_size    <= '0;
            r_ar_id      <= '0;
            r_rd_is_data <= 1'b0;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_acc_dread) begin
                r_ar_addr    <= bus.data_addr;
                r_ar_len     <= 4'd0;
                r_ar_size    <= {1'b0, bus.data_size};
                r_ar_id      <= c_id_data;
                r_rd_is_data <= 1'b1;
            end else if (w_acc_inst) begin
                r_ar_addr    <= bus.inst_addr;
                r_ar_len     <= w_inst_len;
                r_ar_size    <= c_inst_size;
                r_ar_id      <= c_id_inst;
                r_rd_is_data <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------------------- write FSM
    always_comb begin
        w_wr_next   = r_wr_state;
        w_acc_write = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (resetn && bus.data_req && bus.data_wr) begin
                    w_acc_write = 1'b1;
                    w_wr_next   = W_SEND;
                end
            end
            W_SEND: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_wr_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.m_axi_bvalid && w_bready) begin
                    w_wr_next = W_IDLE;
                end
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_state <= W_IDLE;
            r_aw_addr  <= '0;
            r_aw_size  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_acc_write) begin
                r_aw_addr <= bus.data_addr;
                r_aw_size <= {1'b0, bus.data_size};
                r_w_data  <= bus.data_wdata;
                r_w_strb  <= bus.data_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                r_aw_done <= r_aw_done || w_aw_hs;
                r_w_done  <= r_w_done  || w_w_hs;
            end
        end
    end

    // ------------------------------------------------------------- core outputs
    assign bus.inst_addr_ok  = w_acc_inst;
    assign bus.inst_rdata    = bus.m_axi_rdata;
    assign bus.inst_rvalid   = w_inst_beat;
    assign bus.inst_rlast    = w_inst_beat && bus.m_axi_rlast;

    assign bus.data_addr_ok  = w_acc_dread || w_acc_write;
    assign bus.data_rdata    = bus.m_axi_rdata;
    assign bus.data_data_ok  = w_data_beat || (bus.m_axi_bvalid && w_bready);

    // -------------------------------------------------------------- AXI outputs
    assign bus.m_axi_arid    = r_ar_id;
    assign bus.m_axi_araddr  = r_ar_addr;
    assign bus.m_axi_arlen   = r_ar_len;
    assign bus.m_axi_arsize  = r_ar_size;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arlock  = 2'b00;
    assign bus.m_axi_arcache = 4'h0;
    assign bus.m_axi_arprot  = 3'h0;
    assign bus.m_axi_arvalid = (r_rd_state == R_AR);
    assign bus.m_axi_rready  = (r_rd_state == R_DATA);

    assign bus.m_axi_awid    = c_id_data;
    assign bus.m_axi_awaddr  = r_aw_addr;
    assign bus.m_axi_awlen   = 4'd0;
    assign bus.m_axi_awsize  = r_aw_size;
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awlock  = 2'b00;
    assign bus.m_axi_awcache = 4'h0;
    assign bus.m_axi_awprot  = 3'h0;
    assign bus.m_axi_awvalid = w_awvalid;

    assign bus.m_axi_wid     = c_id_data;
    assign bus.m_axi_wdata   = r_w_data;
    assign bus.m_axi_wstrb   = r_w_strb;
    assign bus.m_axi_wlast   = 1'b1;
    assign bus.m_axi_wvalid  = w_wvalid;

    assign bus.m_axi_bready  = w_bready;

    // Response IDs and status codes are deliberately ignored
    assign w_unused = ^{bus.m_axi_rid, bus.m_axi_rresp, bus.m_axi_bid, bus.m_axi_bresp};

endmodule
`default_nettype wire
